io_int_ctrl: RTL

Interrupt controller between the IO subsystem and the MIPS core. It collects interrupt requests from up to NUM_SRC IO modules, applies masking and fixed priority, and raises a single `cpu_intr` to the core. It completes the core's `cpu_inta` handshake by pulsing a one-hot acknowledge back to the winning IO module's `inta` input. It also exposes mask, pending, vector and end-of-interrupt (EOI) registers on a small chip-select bus.

---
 rtl/io_ic_pkg.sv | 29 ++
 rtl/ic_prio_enc.sv | 19 +
 rtl/io_int_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/io_ic_pkg.sv
// Shared types and constants for the IO interrupt controller.
// Consumed by io_int_ctrl (macro IC_EDGE_TRIG_EN selects edge capture).
package io_ic_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_ACK,
      S_SERVICE
   } ic_state_e;

   localparam logic [1:0] IC_REG_MASK = 2'd0;
   localparam logic [1:0] IC_REG_PEND = 2'd1;
   localparam logic [1:0] IC_REG_VEC  = 2'd2;
   localparam logic [1:0] IC_REG_EOI  = 2'd3;

   localparam logic [7:0] IC_MASK_RST = 8'h00;

   // Spurious slot sits one past the last real source.
   function automatic logic [3:0] ic_spur_idx(input int n);
      return 4'(n);
   endfunction

   function automatic logic [31:0] ic_vec(input logic [31:0] base,
                                          input logic [3:0]  idx);
      return base + {26'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/ic_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module ic_prio_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_req,
   output logic         o_valid,
   output logic [2:0]   o_idx
);

   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = 3'(i);
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/io_int_ctrl.sv
// IO interrupt controller: mask, priority, cpu_inta handshake, reg bus.
// `define IC_EDGE_TRIG_EN for sticky edge capture; default is level.
module io_int_ctrl
   import io_ic_pkg::*;
#(
   parameter int          NUM_SRC  = 4,
   parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic [NUM_SRC-1:0] io_inta,
   output logic               cpu_intr,
   input  logic               cpu_inta,
   input  logic               ic_cs,
   input  logic               ic_rd,
   input  logic               ic_wr,
   input  logic [3:0]         addr,
   input  logic [31:0]        din,
   output logic [31:0]        dout
);

   localparam logic [31:0] SPUR_VEC =
      ic_vec(VEC_BASE, ic_spur_idx(NUM_SRC));

   ic_state_e          r_state;
   logic               r_intr;
   logic [NUM_SRC-1:0] r_inta;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_pend;
   logic [31:0]        r_vec;
   logic [31:0]        r_dout;
   logic [NUM_SRC-1:0] r_irq_prev;
   logic               r_inta_prev;

   logic               w_wr;
   logic               w_rd;
   logic [1:0]         w_sel;
   logic [NUM_SRC-1:0] w_act;
   logic               w_valid;
   logic [2:0]         w_idx;
   logic [NUM_SRC-1:0] w_onehot;
   logic               w_rise;
   logic               w_eoi;
   logic [NUM_SRC-1:0] w_pend_nx;
   logic [31:0]        w_rdata;
   logic               w_unused;

   assign w_wr     = ic_cs & ic_wr;
   assign w_rd     = ic_cs & ic_rd;
   assign w_sel    = addr[3:2];
   assign w_act    = r_pend & r_mask;
   assign w_onehot = NUM_SRC'(1) << w_idx;
   assign w_rise   = cpu_inta & ~r_inta_prev;
   assign w_eoi    = w_wr && (w_sel == IC_REG_EOI);
   assign w_unused = ^{din, addr[1:0], r_irq_prev};

   ic_prio_enc #(.N(NUM_SRC)) u_prio (
      .i_req  (w_act),
      .o_valid(w_valid),
      .o_idx  (w_idx)
   );

`ifdef IC_EDGE_TRIG_EN
   logic [NUM_SRC-1:0] w_set;
   logic [NUM_SRC-1:0] w_w1c;
   logic [NUM_SRC-1:0] w_clr;

   // A fresh edge beats a same-cycle W1C or acknowledge clear.
   assign w_set = irq_in & ~r_irq_prev;
   assign w_w1c = (w_wr && (w_sel == IC_REG_PEND)) ?
                  din[NUM_SRC-1:0] : '0;
   assign w_clr = ((r_state == S_ACK) && w_valid) ? w_onehot : '0;
   assign w_pend_nx = (r_pend & ~w_w1c & ~w_clr) | w_set;
`else
   assign w_pend_nx = irq_in;
`endif

   always_comb begin
      w_rdata = '0;
      unique case (w_sel)
         IC_REG_MASK: w_rdata[NUM_SRC-1:0] = r_mask;
         IC_REG_PEND: w_rdata[NUM_SRC-1:0] = r_pend;
         IC_REG_VEC:  w_rdata = r_vec;
         IC_REG_EOI:  w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_intr      <= 1'b0;
         r_inta      <= '0;
         r_mask      <= IC_MASK_RST[NUM_SRC-1:0];
         r_pend      <= '0;
         r_vec       <= '0;
         r_dout      <= '0;
         r_irq_prev  <= '0;
         r_inta_prev <= 1'b0;
      end else begin
         r_irq_prev  <= irq_in;
         r_inta_prev <= cpu_inta;
         r_pend      <= w_pend_nx;
         r_inta      <= '0;
         if (w_wr && (w_sel == IC_REG_MASK))
            r_mask <= din[NUM_SRC-1:0];
         if (w_rd)
            r_dout <= w_rdata;
         unique case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_state <= S_REQ;
                  r_intr  <= 1'b1;
               end
            end
            S_REQ: begin
               if (!w_valid) begin
                  r_state <= S_IDLE;
                  r_intr  <= 1'b0;
               end else if (w_rise) begin
                  r_state <= S_ACK;
                  r_intr  <= 1'b0;
               end
            end
            S_ACK: begin
               if (w_valid) begin
                  r_vec   <= ic_vec(VEC_BASE, {1'b0, w_idx});
                  r_inta  <= w_onehot;
                  r_state <= S_SERVICE;
               end else begin
                  r_vec   <= SPUR_VEC;
                  r_state <= S_IDLE;
               end
            end
            S_SERVICE: begin
               if (w_eoi) r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_intr = r_intr;
   assign io_inta  = r_inta;
   assign dout     = r_dout;

endmodule
